nrd_scheduler: RTL and testbench
================================

// Module: nrd_scheduler
// PURPOSE
//  Shares one non-restoring divider (nrd) among NREQ requesters. Round-robin arbitration, operand capture,
//  bit-length computation, newInput pulse generation, done tracking, result return via valid/ready.
//  Divide-by-zero and dividend-shorter-than-divisor handled locally without using the divider.
//  Divider hang detection via watchdog. Sits between client blocks and the single nrd instance.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  TIMEOUT  200  max cycles WAIT_DONE may last before error response
// PORTS
//  clk             in   1          rising-edge clock
//  rst_n           in   1          synchronous active-low reset
//  req_valid       in   NREQ       per-requester request valid
//  req_ready       out  NREQ       per-requester accept; one-hot or zero
//  req_dividend    in   NREQ*32    packed dividends, requester i at [32i+31:32i]
//  req_divisor     in   NREQ*32    packed divisors, same packing
//  resp_valid      out  1          response valid
//  resp_ready      in   1          response consumed
//  resp_id         out  3          index of requester served
//  resp_quotient   out  32         quotient
//  resp_remainder  out  33 signed  remainder
//  resp_err        out  2          0 ok, 1 divide-by-zero, 2 timeout
//  resp_num_add    out  6          divider add count (0 on bypass)
//  resp_num_sub    out  6          divider subtract count (0 on bypass)
//  div_dividend    out  32         to nrd dividend
//  div_divisor     out  32         to nrd divisor
//  div_len_dvd     out  7 signed   to nrd len_dividend
//  div_len_dvs     out  7 signed   to nrd len_divisor
//  div_new_input   out  1          to nrd newInput; one-cycle pulse
//  div_quotient    in   32         from nrd
//  div_remainder   in   33 signed  from nrd
//  div_done        in   1          from nrd
//  div_num_add     in   6          from nrd
//  div_num_sub     in   6          from nrd
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, rr pointer 0, every output 0, watchdog 0. Takes priority over all.
//  Reset mid-operation abandons the job, with no response. The nrd is not reset.
//  States: IDLE -> LAUNCH -> WAIT_CLR -> WAIT_DONE -> RESP -> IDLE. Bypass path: IDLE -> RESP.
//  IDLE:
//   - Grant only when div_done=1 (divider quiescent).
//   - Winner = first req_valid at or after rr pointer, wrapping.
//   - req_ready[winner]=1 combinationally that cycle; handshake = valid&ready. Capture operands and id.
//   - rr pointer <= winner+1 mod NREQ.
//  Length: len(x) = index of MSB one + 1; len(0) = 0. Computed on captured operands, 7 bits, range 0..32.
//  Bypass cases (no divider use, next state RESP):
//   - divisor=0: quotient=32'hFFFFFFFF, remainder=dividend zero-extended, err=1.
//   - len(dividend) < len(divisor): quotient=0, remainder=dividend, err=0.
//   - Both bypass: num_add=num_sub=0.
//  LAUNCH:
//   - div_dividend/divisor/len outputs driven from capture regs; held stable until leaving WAIT_DONE.
//   - div_new_input=1 for exactly this one cycle.
//  WAIT_CLR: wait for div_done=0 (divider accepted the job), then go to WAIT_DONE.
//  WAIT_DONE:
//   - On div_done=1: latch quotient, remainder, num_add, num_sub; err=0; go to RESP.
//   - Watchdog counts cycles spent in WAIT_CLR+WAIT_DONE. On reaching TIMEOUT: err=2, quotient=0,
//     remainder=0, go to RESP. Watchdog cleared on entry to LAUNCH.
//  RESP:
//   - resp_* registered and stable while resp_valid=1.
//   - On resp_ready=1: resp_valid drops next cycle, go to IDLE.
//   - No new grant until the cycle after the response completes (max one job in flight).
//  Requester starvation bound: with NREQ continuously valid, any requester is served within NREQ jobs.
//  A requester may drop req_valid before grant; no state change results.
// TESTING
//  1 Reset: rst_n=0 3 cycles with req_valid=4'hF -> all outputs 0, req_ready=0.
//  2 Single job: req0 100/7 -> div_new_input pulse with len 7/3; resp quot=14, rem=2, id=0, err=0.
//  3 Round-robin: all four valid continuously -> resp_id sequence 0,1,2,3,0; no req_ready while busy.
//  4 Bypass: req2 5/0 -> resp err=1, quot=FFFFFFFF, rem=5, no div_new_input. req1 3/9 -> quot=0, rem=3, err=0.
//  5 Timeout: div_done tied 1, after launch forced 0 -> resp err=2 after TIMEOUT cycles; arbiter then stalls
//    in IDLE until div_done=1.
//  6 Backpressure/reset: resp_ready=0 for 10 cycles -> resp fields stable; rst_n=0 in WAIT_DONE -> IDLE, no resp.

Source files
------------

// File: rtl/nrd_scheduler.sv
// Round-robin front end sharing one non-restoring divider; bypasses divide-by-zero and short dividends locally.
// Bypass answers 1 cycle after grant; one job in flight, no new grant while a response waits for o_resp_ready.
module nrd_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 200
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        i_req_valid,
    output logic [NREQ-1:0]        o_req_ready,
    input  logic [NREQ*32-1:0]     i_req_dividend,
    input  logic [NREQ*32-1:0]     i_req_divisor,
    output logic                   o_resp_valid,
    input  logic                   i_resp_ready,
    output logic [2:0]             o_resp_id,
    output logic [31:0]            o_resp_quotient,
    output logic signed [32:0]     o_resp_remainder,
    output logic [1:0]             o_resp_err,
    output logic [5:0]             o_resp_num_add,
    output logic [5:0]             o_resp_num_sub,
    output logic [31:0]            o_div_dividend,
    output logic [31:0]            o_div_divisor,
    output logic signed [6:0]      o_div_len_dvd,
    output logic signed [6:0]      o_div_len_dvs,
    output logic                   o_div_new_input,
    input  logic [31:0]            i_div_quotient,
    input  logic signed [32:0]     i_div_remainder,
    input  logic                   i_div_done,
    input  logic [5:0]             i_div_num_add,
    input  logic [5:0]             i_div_num_sub
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_CLR,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [IDW-1:0]        r_rr;
    logic [WDW-1:0]        r_wdog;
    logic                  r_resp_valid;
    logic [IDW-1:0]        r_resp_id;
    logic [31:0]           r_resp_quot;
    logic signed [32:0]    r_resp_rem;
    logic [1:0]            r_resp_err;
    logic [5:0]            r_resp_nadd;
    logic [5:0]            r_resp_nsub;
    logic [31:0]           r_div_dvd;
    logic [31:0]           r_div_dvs;
    logic [6:0]            r_len_dvd;
    logic [6:0]            r_len_dvs;
    logic                  r_new_input;

    logic                  w_found;
    logic [IDW-1:0]        w_win;
    logic [IDW-1:0]        w_rr_next;
    int                    w_idx;
    logic                  w_grant;
    logic [31:0]           w_dvd;
    logic [31:0]           w_dvs;
    logic [6:0]            w_len_dvd;
    logic [6:0]            w_len_dvs;
    logic                  w_timeout;

    function automatic logic [6:0] f_len(input logic [31:0] x);
        logic [6:0] l;
        l = 7'd0;
        for (int b = 0; b < 32; b++) begin
            if (x[b]) l = 7'(b + 1);
        end
        return l;
    endfunction

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_idx);
            end
        end
    end

    assign w_grant   = i_rst_n && (r_state == S_IDLE) && i_div_done && w_found;
    assign w_rr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_dvd     = i_req_dividend[w_win*32 +: 32];
    assign w_dvs     = i_req_divisor[w_win*32 +: 32];
    assign w_len_dvd = f_len(w_dvd);
    assign w_len_dvs = f_len(w_dvs);
    assign w_timeout = (r_wdog == WDW'(TIMEOUT - 1));

    always_comb begin
        o_req_ready = '0;
        if (w_grant) o_req_ready[w_win] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_rr         <= '0;
            r_wdog       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_quot  <= '0;
            r_resp_rem   <= '0;
            r_resp_err   <= 2'd0;
            r_resp_nadd  <= '0;
            r_resp_nsub  <= '0;
            r_div_dvd    <= '0;
            r_div_dvs    <= '0;
            r_len_dvd    <= '0;
            r_len_dvs    <= '0;
            r_new_input  <= 1'b0;
        end else begin
            r_new_input <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_rr      <= w_rr_next;
                        r_resp_id <= w_win;
                        if (w_dvs == 32'd0) begin
                            r_resp_quot  <= '1;
                            r_resp_rem   <= {1'b0, w_dvd};
                            r_resp_err   <= 2'd1;
                            r_resp_nadd  <= '0;
                            r_resp_nsub  <= '0;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else if (w_len_dvd < w_len_dvs) begin
                            r_resp_quot  <= '0;
                            r_resp_rem   <= {1'b0, w_dvd};
                            r_resp_err   <= 2'd0;
                            r_resp_nadd  <= '0;
                            r_resp_nsub  <= '0;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_div_dvd   <= w_dvd;
                            r_div_dvs   <= w_dvs;
                            r_len_dvd   <= w_len_dvd;
                            r_len_dvs   <= w_len_dvs;
                            r_new_input <= 1'b1;
                            r_wdog      <= '0;
                            r_state     <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT_CLR;
                end
                // The divider only owns the job once it has dropped done.
                S_WAIT_CLR: begin
                    if (w_timeout) begin
                        r_resp_quot  <= '0;
                        r_resp_rem   <= '0;
                        r_resp_err   <= 2'd2;
                        r_resp_nadd  <= '0;
                        r_resp_nsub  <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                        if (!i_div_done) r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_div_done) begin
                        r_resp_quot  <= i_div_quotient;
                        r_resp_rem   <= i_div_remainder;
                        r_resp_err   <= 2'd0;
                        r_resp_nadd  <= i_div_num_add;
                        r_resp_nsub  <= i_div_num_sub;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (w_timeout) begin
                        r_resp_quot  <= '0;
                        r_resp_rem   <= '0;
                        r_resp_err   <= 2'd2;
                        r_resp_nadd  <= '0;
                        r_resp_nsub  <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_resp_valid     = r_resp_valid;
    assign o_resp_id        = 3'(r_resp_id);
    assign o_resp_quotient  = r_resp_quot;
    assign o_resp_remainder = r_resp_rem;
    assign o_resp_err       = r_resp_err;
    assign o_resp_num_add   = r_resp_nadd;
    assign o_resp_num_sub   = r_resp_nsub;
    assign o_div_dividend   = r_div_dvd;
    assign o_div_divisor    = r_div_dvs;
    assign o_div_len_dvd    = r_len_dvd;
    assign o_div_len_dvs    = r_len_dvs;
    assign o_div_new_input  = r_new_input;

endmodule

// File: tb/tb_nrd_scheduler.sv
// Random and directed stimulus for nrd_scheduler against a transaction-level scoreboard and a behavioural divider.
module tb_nrd_scheduler;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_dividend, req_divisor;
    logic                 resp_valid, resp_ready;
    logic [2:0]           resp_id;
    logic [31:0]          resp_quot;
    logic signed [32:0]   resp_rem;
    logic [1:0]           resp_err;
    logic [5:0]           resp_nadd, resp_nsub;
    logic [31:0]          div_dvd, div_dvs;
    logic signed [6:0]    div_len_dvd, div_len_dvs;
    logic                 div_new_input;
    logic [31:0]          div_quot;
    logic signed [32:0]   div_rem;
    logic                 div_done;
    logic [5:0]           div_nadd, div_nsub;

    nrd_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_dividend(req_dividend), .i_req_divisor(req_divisor),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_id(resp_id), .o_resp_quotient(resp_quot), .o_resp_remainder(resp_rem),
        .o_resp_err(resp_err), .o_resp_num_add(resp_nadd), .o_resp_num_sub(resp_nsub),
        .o_div_dividend(div_dvd), .o_div_divisor(div_dvs),
        .o_div_len_dvd(div_len_dvd), .o_div_len_dvs(div_len_dvs), .o_div_new_input(div_new_input),
        .i_div_quotient(div_quot), .i_div_remainder(div_rem), .i_div_done(div_done),
        .i_div_num_add(div_nadd), .i_div_num_sub(div_nsub)
    );

    typedef struct {
        logic [2:0]  id;
        logic [31:0] dvd, dvs, quot;
        logic [32:0] rem;
        logic [1:0]  err;
        logic [5:0]  nadd, nsub;
        bit          bypass;
    } job_t;

    job_t sb[$];
    int   ids_seen[$];
    int   n_chk = 0, n_err = 0;
    int   m_rr = 0, m_grant_id = -1, busy_cycles = 0;
    bit   m_busy = 0, m_launch_due = 0, rst_edge = 0;
    int   dv_cnt = -1, dv_lat_min = 2, dv_lat_max = 12;
    bit   dv_hang = 0;
    logic [31:0] dv_a = 0, dv_b = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_len(input logic [31:0] x);
        longint v = longint'(x);
        int n = 0;
        while (v > 0) begin
            v = v / 2;
            n++;
        end
        return 7'(n);
    endfunction

    function automatic logic [5:0] fake_nadd(input logic [31:0] a, input logic [31:0] b);
        return 6'((a ^ b) % 32'd61);
    endfunction

    function automatic logic [5:0] fake_nsub(input logic [31:0] a, input logic [31:0] b);
        return 6'(({32'd0, a} + {32'd0, b}) % 64'd53);
    endfunction

    // Predicts the grant for this cycle and checks any response against the scoreboard head.
    task automatic monitor();
        logic [NREQ-1:0] exp_rdy;
        int w;
        job_t j;
        exp_rdy = '0;
        m_grant_id = -1;
        w = -1;
        if (!rst_n) begin
            sb.delete();
            m_busy = 0; m_rr = 0; m_launch_due = 0; busy_cycles = 0;
        end else if (!m_busy && div_done) begin
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req_valid[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        chk_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (w >= 0) begin
            j.id = 3'(w);
            j.dvd = req_dividend[w*32 +: 32];
            j.dvs = req_divisor[w*32 +: 32];
            j.nadd = 0; j.nsub = 0; j.bypass = 1;
            if (j.dvs == 0) begin
                j.quot = 32'hFFFF_FFFF; j.rem = {1'b0, j.dvd}; j.err = 2'd1;
            end else if (ref_len(j.dvd) < ref_len(j.dvs)) begin
                j.quot = 0; j.rem = {1'b0, j.dvd}; j.err = 2'd0;
            end else if (dv_hang) begin
                j.quot = 0; j.rem = 0; j.err = 2'd2; j.bypass = 0;
            end else begin
                j.quot = j.dvd / j.dvs; j.rem = {1'b0, j.dvd % j.dvs}; j.err = 2'd0;
                j.nadd = fake_nadd(j.dvd, j.dvs); j.nsub = fake_nsub(j.dvd, j.dvs); j.bypass = 0;
            end
            sb.push_back(j);
            m_rr = (w + 1) % NREQ;
            m_busy = 1; m_launch_due = !j.bypass; m_grant_id = w; busy_cycles = 0;
        end
        if (!rst_edge) begin
            chk_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        end else if (rst_n) begin
            if (resp_valid) begin
                if (sb.size() == 0) chk_eq("resp_spurious", 64'(resp_valid), 64'd0);
                else begin
                    j = sb[0];
                    chk_eq("resp_id", 64'(resp_id), 64'(j.id));
                    chk_eq("resp_quot", 64'(resp_quot), 64'(j.quot));
                    chk_eq("resp_rem", 64'($unsigned(resp_rem)), 64'(j.rem));
                    chk_eq("resp_err", 64'(resp_err), 64'(j.err));
                    if (j.err != 2'd2) begin
                        chk_eq("resp_nadd", 64'(resp_nadd), 64'(j.nadd));
                        chk_eq("resp_nsub", 64'(resp_nsub), 64'(j.nsub));
                    end
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        m_busy = 0;
                        ids_seen.push_back(int'(j.id));
                    end
                end
            end else if (m_busy) begin
                busy_cycles++;
                if (busy_cycles > TIMEOUT + 40) begin
                    chk_eq("resp_missing", 64'(busy_cycles), 64'(TIMEOUT + 40));
                    sb.delete(); m_busy = 0; busy_cycles = 0;
                end
            end
        end
    endtask

    // Behavioural divider: drops done on newInput, returns a/b after a random latency.
    task automatic divmodel();
        job_t j;
        chk_eq("new_input", 64'(div_new_input), 64'(m_launch_due));
        if (m_launch_due && sb.size() > 0) begin
            j = sb[$];
            chk_eq("div_dvd", 64'(div_dvd), 64'(j.dvd));
            chk_eq("div_dvs", 64'(div_dvs), 64'(j.dvs));
            chk_eq("div_len_dvd", 64'($unsigned(div_len_dvd)), 64'(ref_len(j.dvd)));
            chk_eq("div_len_dvs", 64'($unsigned(div_len_dvs)), 64'(ref_len(j.dvs)));
        end
        m_launch_due = 0;
        if (div_new_input) begin
            dv_a = div_dvd; dv_b = div_dvs; div_done = 1'b0;
            dv_cnt = dv_hang ? -1 : $urandom_range(dv_lat_max, dv_lat_min);
        end else if (dv_cnt > 0) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
                div_quot = (dv_b == 0) ? 32'd0 : dv_a / dv_b;
                div_rem  = (dv_b == 0) ? 33'sd0 : $signed({1'b0, dv_a % dv_b});
                div_nadd = fake_nadd(dv_a, dv_b);
                div_nsub = fake_nsub(dv_a, dv_b);
                div_done = 1'b1;
                dv_cnt = -1;
            end
        end
    endtask

    task automatic tick();
        #3;
        monitor();
        @(posedge clk);
        rst_edge = rst_n;
        #1;
        divmodel();
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_dividend[i*32 +: 32] = a;
        req_divisor[i*32 +: 32]  = b;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((m_busy || sb.size() != 0) && n < max) begin
            tick();
            n++;
        end
        chk_eq("idle_bound", 64'(n < max), 64'd1);
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        set_req(i, a, b);
        req_valid[i] = 1'b1;
        do begin
            tick();
            n++;
        end while (m_grant_id != i && n < 400);
        req_valid[i] = 1'b0;
        chk_eq("grant_bound", 64'(n < 400), 64'd1);
    endtask

    task automatic rand_ops(output logic [31:0] a, output logic [31:0] b);
        case ($urandom_range(5, 0))
            0: begin a = $urandom; b = 0; end
            1: begin a = $urandom_range(255, 0); b = $urandom_range(65535, 256); end
            2: begin a = $urandom_range(1000, 0); b = $urandom_range(50, 1); end
            3: begin a = $urandom; b = $urandom; end
            4: begin a = $urandom; b = $urandom_range(7, 1); end
            default: begin
                a = $urandom_range(32'hFFFF_FFFF, 32'h8000_0000);
                b = $urandom_range(32'hFFFF_FFFF, 32'h8000_0000);
            end
        endcase
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        rst_n = 1'b0; req_valid = '1; req_dividend = '0; req_divisor = '0; resp_ready = 1'b1;
        div_done = 1'b1; div_quot = '0; div_rem = '0; div_nadd = '0; div_nsub = '0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        chk_eq("rst_req_ready", 64'(req_ready), 64'd0);
        chk_eq("rst_resp_valid_out", 64'(resp_valid), 64'd0);
        chk_eq("rst_resp_fields", 64'({resp_id, resp_err, resp_nadd, resp_nsub}), 64'd0);
        chk_eq("rst_resp_quot", 64'(resp_quot), 64'd0);
        chk_eq("rst_resp_rem", 64'($unsigned(resp_rem)), 64'd0);
        chk_eq("rst_div_ops", {div_dvd, div_dvs}, 64'd0);
        chk_eq("rst_div_ctl", 64'({div_len_dvd, div_len_dvs, div_new_input}), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        issue(0, 32'd100, 32'd7);
        chk_eq("single_new_input", 64'(div_new_input), 64'd1);
        chk_eq("single_len_dvd", 64'($unsigned(div_len_dvd)), 64'd7);
        chk_eq("single_len_dvs", 64'($unsigned(div_len_dvs)), 64'd3);
        wait_idle(100);

        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        ids_seen.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'd1000 + 32'(i), 32'd3 + 32'(i));
        req_valid = '1;
        n = 0;
        while (ids_seen.size() < 5 && n < 500) begin tick(); n++; end
        req_valid = '0;
        wait_idle(100);
        chk_eq("rr_bound", 64'(ids_seen.size() >= 5), 64'd1);
        if (ids_seen.size() >= 5)
            for (int k = 0; k < 5; k++) chk_eq("rr_order", 64'(ids_seen[k]), 64'(k % NREQ));

        issue(2, 32'd5, 32'd0);
        wait_idle(50);
        issue(1, 32'd3, 32'd9);
        wait_idle(50);

        resp_ready = 1'b0;
        issue(3, 32'd1000, 32'd3);
        n = 0;
        while (!resp_valid && n < 100) begin tick(); n++; end
        repeat (10) tick();
        chk_eq("bp_valid_held", 64'(resp_valid), 64'd1);
        resp_ready = 1'b1;
        wait_idle(50);

        dv_hang = 1;
        issue(0, 32'd1000, 32'd10);
        n = 0;
        while (!resp_valid && n < TIMEOUT + 20) begin tick(); n++; end
        chk_eq("tmo_latency", 64'(n >= TIMEOUT - 1 && n <= TIMEOUT + 3), 64'd1);
        wait_idle(20);
        req_valid = '1;
        repeat (10) tick();
        chk_eq("tmo_stall", 64'(req_ready), 64'd0);
        dv_hang = 0;
        div_done = 1'b1;
        n = 0;
        while (m_grant_id < 0 && n < 20) begin tick(); n++; end
        chk_eq("tmo_regrant", 64'(n < 20), 64'd1);
        req_valid = '0;
        wait_idle(100);

        dv_lat_min = 40; dv_lat_max = 40;
        issue(0, 32'd12345, 32'd17);
        repeat (5) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        repeat (60) begin
            tick();
            if (resp_valid) n++;
        end
        chk_eq("rst_mid_no_resp", 64'(n), 64'd0);
        dv_lat_min = 2; dv_lat_max = 12;

        for (int c = 0; c < 3000; c++) begin
            if (m_grant_id >= 0) req_valid[m_grant_id] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && i != m_grant_id) begin
                    if ($urandom_range(7, 0) == 0) req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(2, 0) == 0) begin
                    rand_ops(a, b);
                    set_req(i, a, b);
                    req_valid[i] = 1'b1;
                end
            end
            resp_ready = ($urandom_range(9, 0) < 7);
            tick();
        end
        req_valid = '0;
        resp_ready = 1'b1;
        wait_idle(500);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
